// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: datapath width,
// multiply/divide opcodes and default latencies.
package mips_pkg;

  localparam int XLEN            = 32;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } mdop_t;

  function automatic logic md_is_div(
    input logic [3:0] op
  );
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_long(
    input logic [3:0] op
  );
    return (op == MD_MULT) || (op == MD_MULTU) ||
           md_is_div(op);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational mult/div datapath producing {hi, lo}
// and a divide-by-zero flag.
module mdu_arith
  import mips_pkg::*;
(
  input  logic [3:0]        op,
  input  logic [XLEN-1:0]   rs,
  input  logic [XLEN-1:0]   rt,
  output logic [2*XLEN-1:0] res,
  output logic              div0
);

  logic            sgn;
  logic            neg_q;
  logic            neg_r;
  logic [XLEN-1:0] ua;
  logic [XLEN-1:0] ub;
  logic [XLEN-1:0] q;
  logic [XLEN-1:0] r;

  always_comb begin
    sgn   = (op == MD_MULT) || (op == MD_DIV);
    div0  = md_is_div(op) && (rt == '0);
    ua    = (sgn && rs[XLEN-1]) ? -rs : rs;
    ub    = (sgn && rt[XLEN-1]) ? -rt : rt;
    neg_q = sgn && (rs[XLEN-1] ^ rt[XLEN-1]);
    neg_r = sgn && rs[XLEN-1];
    q     = '0;
    r     = '0;
    // Divide magnitudes so 0x80000000 / -1 wraps cleanly.
    if (md_is_div(op) && !div0) begin
      q = ua / ub;
      r = ua % ub;
    end
    res = '0;
    unique case (1'b1)
      (op == MD_MULT):
        res = {{XLEN{rs[XLEN-1]}}, rs} *
              {{XLEN{rt[XLEN-1]}}, rt};
      (op == MD_MULTU):
        res = {{XLEN{1'b0}}, rs} *
              {{XLEN{1'b0}}, rt};
      md_is_div(op):
        res = {neg_r ? -r : r, neg_q ? -q : q};
      default:
        res = '0;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// EX-stage multiply/divide unit: owns HI/LO and
// models multi-cycle latency with a busy counter.
module mdu
  import mips_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [3:0]      mdop,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  output logic            busy,
  output logic [XLEN-1:0] mdout
);

  logic [XLEN-1:0]   hi;
  logic [XLEN-1:0]   lo;
  logic [XLEN-1:0]   hi_pend;
  logic [XLEN-1:0]   lo_pend;
  logic [3:0]        cnt;
  logic [2*XLEN-1:0] res;
  logic              div0;

  mdu_arith u_arith (
    .op   (mdop),
    .rs   (rs_val),
    .rt   (rt_val),
    .res  (res),
    .div0 (div0)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi      <= '0;
      lo      <= '0;
      hi_pend <= '0;
      lo_pend <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
    end else if (busy) begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) begin
        hi   <= hi_pend;
        lo   <= lo_pend;
        busy <= 1'b0;
      end
    end else if (start) begin
      if (md_is_long(mdop)) begin
        // HI/LO cannot change while busy, so a zero
        // divisor simply re-commits the current values.
        {hi_pend, lo_pend} <= div0 ? {hi, lo} : res;
        cnt  <= md_is_div(mdop) ? 4'(DIV_CYCLES)
                                : 4'(MULT_CYCLES);
        busy <= 1'b1;
      end
    end else if (mdop == MD_MTHI) begin
      hi <= rs_val;
    end else if (mdop == MD_MTLO) begin
      lo <= rs_val;
    end
  end

  always_comb begin
    mdout = '0;
    unique case (1'b1)
      (mdop == MD_MFHI): mdout = hi;
      (mdop == MD_MFLO): mdout = lo;
      default:           mdout = '0;
    endcase
  end

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit in the EX stage of the pipelined MIPS core. It consumes the forwarded rs/rt operand values that originate at the register-file read ports and owns the architectural HI/LO registers. It models multi-cycle mult/div latency with a busy counter, and the hazard unit stalls the pipeline on `start | busy`. Implements mult, multu, div, divu, mfhi, mflo, mthi and mtlo.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu.
- `DIV_CYCLES`, default 10: busy cycles for div/divu.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low; `reset==0` immediately clears all state.
- `start`  in  1  one-cycle request for mult/multu/div/divu; qualified by `mdop`.
- `mdop`  in  4  operation code, encodings from the shared package; `MD_NONE` means idle.
- `rs_val`  in  32  forwarded rs operand.
- `rt_val`  in  32  forwarded rt operand.
- `busy`  out  1  an operation is in flight.
- `mdout`  out  32  HI for mfhi, LO for mflo, otherwise 0; combinational.

## Operation
- State: `hi`, `lo`, `hi_pend`, `lo_pend` (each 32 bits), `cnt` (4 bits), `busy`.
- IDLE (`busy=0`):
  - `start=1` with a mult-class op latches the result into `*_pend`, loads `cnt` with the cycle count and sets `busy`.
  - `start=1` with any non-mult op is ignored.
- Arithmetic:
  - mult: signed 32×32→64; `hi`=[63:32], `lo`=[31:0].
  - multu: same as mult, unsigned.
  - div, divu: `lo`=quotient, `hi`=remainder.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - div 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0.
  - Divisor 0: `hi`/`lo` are left unchanged when the operation completes. Busy timing still applies.
- BUSY (`busy=1`):
  - `cnt` decrements each cycle.
  - On the edge where `cnt` goes 1→0, `hi`/`lo` load from `*_pend` and `busy` clears.
- mthi/mtlo:
  - Write `rs_val` into `hi`/`lo` at the edge when `busy=0` and `start=0`.
  - Ignored while busy; the hazard unit prevents this case.
- mfhi/mflo:
  - `mdout` reflects the committed `hi`/`lo` combinationally.
  - The value is not valid while busy; the hazard unit stalls.
- `start` while busy: ignored. The in-flight operation continues unaffected.
- Reset asserted mid-operation: `hi`, `lo`, `*_pend`, `cnt` and `busy` all go to 0 immediately. The pending result is discarded.

## Timing
- Reset values: `busy=0`, `hi=lo=0`, so `mdout=0`.
- With `start` sampled at edge k and latency N:
  - `busy` is 1 from edge k through edge k+N−1.
  - `busy` is 0 after edge k+N, and `hi`/`lo` are updated at that same edge.
- A new `start` is accepted at edge k+N+1 at the earliest, or at k+N if `busy` is already 0 in that cycle.
- Back-to-back mult→mflo: mflo reads the new `lo` in the cycle after `busy` falls.
- mthi/mtlo latency: 1 edge; visible on `mdout` the next cycle.

## Structure
- Shared package `mips_pkg` holds:
  - `mdop` encodings: `MD_NONE`, `MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`, `MD_MFHI`, `MD_MFLO`, `MD_MTHI`, `MD_MTLO`.
  - Default cycle constants.
  - Width 32.
- One combinational sub-module, `mdu_arith`: takes op, rs, rt and produces the 64-bit {hi, lo} result plus a `div0` flag.
- The top level holds the counter, the pending registers and HI/LO.

## Test plan
- mult 0xFFFFFFFE × 3:
  - `busy` high for 5 cycles.
  - Then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA.
  - multu with the same operands gives `hi`=2, `lo`=0xFFFFFFFA.
- div −7 / 2:
  - `busy` high for 10 cycles.
  - Then `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - divu 7/2 gives `lo`=3, `hi`=1.
- Overflow and divide-by-zero:
  - div 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0.
  - div by 0 after mthi 0x11 / mtlo 0x22 leaves `hi`=0x11, `lo`=0x22.
- mthi 0xABCD, then mfhi the next cycle: `mdout`=0xABCD.
- Ignored requests while busy:
  - A second `start` at busy cycle 2 is ignored: only the first result commits, and `busy` falls on schedule.
  - mtlo while busy is ignored.
- Asynchronous reset:
  - Drop `reset` to 0 at busy cycle 3 of a div, mid-cycle.
  - `busy`, `hi` and `lo` read 0 immediately, with no clock edge.
  - No commit occurs after `reset` returns to 1.
